prm_edge_mask_accum: RTL and testbench

//  Downstream stage of the prm_oblgc_chk* checker bank. Streams obstacle point codes (15b, bits map to

---
 rtl/prm_edge_pkg.sv | 17 +
 rtl/prm_popcnt.sv | 17 +
 rtl/prm_edge_mask_accum.sv | 181 ++++++++++++++++++
 tb/tb_prm_edge_mask_accum.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_edge_pkg.sv
// Shared types and constants for the edge-mask accumulator and its helpers.
package prm_edge_pkg;

    localparam int CODE_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic int words(input int num_edges, input int word_w);
        return num_edges / word_w;
    endfunction

endpackage

// File: rtl/prm_popcnt.sv
// Combinational population count of one drain word.
module prm_popcnt #(
    parameter int WORD_W = 32,
    localparam int CW = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] data_i,
    output logic [CW-1:0]     count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// Broadcasts obstacle codes to the checker bank, ORs the returned edge masks into a
// per-frame blocked vector and drains it word by word. Optional popcount: PRM_EDGE_POPCNT_EN.
module prm_edge_mask_accum #(
    parameter int NUM_EDGES = 1024,
    parameter int WORD_W    = 32,
    parameter int CODE_W    = prm_edge_pkg::CODE_W,
    localparam int WORDS    = prm_edge_pkg::words(NUM_EDGES, WORD_W),
    localparam int AW       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int BCW      = $clog2(NUM_EDGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [CODE_W-1:0]    pt_code,
    input  logic                 pt_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] edge_mask_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [AW-1:0]        out_addr,
    output logic                 out_last,
    output logic                 busy,
`ifdef PRM_EDGE_POPCNT_EN
    output logic [BCW-1:0]       blk_count,
`endif
    output logic [15:0]          pt_count
);

    import prm_edge_pkg::*;

    state_e                          state_q, state_d;
    logic [CODE_W-1:0]               chk_code_q, chk_code_d;
    logic                            acc_pend_q, acc_pend_d;
    logic                            last_pend_q, last_pend_d;
    logic [WORDS-1:0][WORD_W-1:0]    blocked_q, blocked_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [WORD_W-1:0]               out_data_q, out_data_d;
    logic [AW-1:0]                   out_addr_q, out_addr_d;
    logic                            out_last_q, out_last_d;
    logic [AW-1:0]                   nxt_addr;

    assign nxt_addr = out_addr_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        chk_code_d  = chk_code_q;
        acc_pend_d  = 1'b0;
        last_pend_d = 1'b0;
        blocked_d   = blocked_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;

        // The mask returned for the code broadcast last cycle lands one clock after acceptance.
        if (acc_pend_q) begin
            blocked_d = blocked_q | edge_mask_in;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = ACCUM;
                    blocked_d = '0;
                    cnt_d     = '0;
                end
            end
            ACCUM: begin
                if (pt_valid) begin
                    chk_code_d = pt_code;
                    acc_pend_d = 1'b1;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (pt_last) begin
                        state_d     = FLUSH;
                        last_pend_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // blocked_d already holds the final code's mask, so word 0 is complete here.
                if (last_pend_q) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_addr_d  = '0;
                    out_data_d  = blocked_d[0];
                    out_last_d  = (WORDS == 1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_addr_d = nxt_addr;
                        out_data_d = blocked_q[nxt_addr];
                        out_last_d = (nxt_addr == AW'(WORDS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chk_code_q  <= '0;
            acc_pend_q  <= 1'b0;
            last_pend_q <= 1'b0;
            blocked_q   <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            chk_code_q  <= chk_code_d;
            acc_pend_q  <= acc_pend_d;
            last_pend_q <= last_pend_d;
            blocked_q   <= blocked_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
        end
    end

    assign pt_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign chk_code  = chk_code_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign pt_count  = cnt_q;

`ifdef PRM_EDGE_POPCNT_EN
    localparam int PCW = $clog2(WORD_W + 1);

    logic [PCW-1:0] word_pop;
    logic [BCW-1:0] blk_q, blk_d;

    prm_popcnt #(
        .WORD_W (WORD_W)
    ) u_popcnt (
        .data_i  (out_data_q),
        .count_o (word_pop)
    );

    always_comb begin
        blk_d = blk_q;
        if (state_q == IDLE && frame_start) begin
            blk_d = '0;
        end else if (state_q == DRAIN && out_ready) begin
            blk_d = blk_q + BCW'(word_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_count = blk_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Randomized self-checking bench for prm_edge_mask_accum with a stub checker bank.
`timescale 1ns/1ps
module tb_prm_edge_mask_accum;

    localparam int N     = 128;
    localparam int W     = 32;
    localparam int WORDS = N / W;
    localparam int AW    = $clog2(WORDS);
    localparam int CW    = 15;
    localparam int IW    = $clog2(N);
    localparam int BCW   = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, frame_start, pt_valid, pt_last, out_ready;
    logic          pt_ready, out_valid, out_last, busy;
    logic [CW-1:0] pt_code, chk_code;
    logic [N-1:0]  edge_mask;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_addr;
    logic [15:0]   pt_count;
`ifdef PRM_EDGE_POPCNT_EN
    logic [BCW-1:0] blk_count;
`endif

    int checks   = 0;
    int failures = 0;
    int mask_mode = 0;

    logic [N-1:0] exp_blk;
    int           exp_cnt;
    logic [W-1:0] got_data[$];
    int           got_addr[$];
    bit           got_last[$];
    int           stall_err;

    always #5 clk = ~clk;

    prm_edge_mask_accum #(.NUM_EDGES(N), .WORD_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pt_valid     (pt_valid),
        .pt_ready     (pt_ready),
        .pt_code      (pt_code),
        .pt_last      (pt_last),
        .chk_code     (chk_code),
        .edge_mask_in (edge_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_last     (out_last),
        .busy         (busy),
`ifdef PRM_EDGE_POPCNT_EN
        .blk_count    (blk_count),
`endif
        .pt_count     (pt_count)
    );

    // Stub checker bank: each code blocks edge (code mod N), plus a second edge in mode 1.
    function automatic logic [N-1:0] mask_fn(input logic [CW-1:0] c, input int mode);
        logic [N-1:0] m;
        m = '0;
        m[IW'(int'(c) % N)] = 1'b1;
        if (mode != 0) m[IW'((int'(c) * 7 + 3) % N)] = 1'b1;
        return m;
    endfunction

    always_comb edge_mask = mask_fn(chk_code, mask_mode);

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        exp_blk = '0;
        exp_cnt = 0;
    endtask

    task automatic send_code(input logic [CW-1:0] code, input bit last, input int gap_max);
        int t;
        repeat ($urandom_range(0, gap_max)) begin
            pt_valid = 1'b0;
            pt_code  = CW'($urandom);
            pt_last  = 1'($urandom);
            @(negedge clk);
        end
        pt_valid = 1'b1;
        pt_code  = code;
        pt_last  = last;
        t = 0;
        while (!pt_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pt_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout pt_ready=%0b required=1", pt_ready);
        end else begin
            @(negedge clk);
            exp_blk = exp_blk | mask_fn(code, mask_mode);
            if (exp_cnt < 65535) exp_cnt++;
        end
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    // Collects drained words; stalls are 0 (none), 1 (random 0..2 clks) or 2 (5 clks per word).
    task automatic drain(input int mode);
        logic [W-1:0]  d;
        logic [AW-1:0] a;
        logic          l;
        int            t;
        got_data.delete();
        got_addr.delete();
        got_last.delete();
        stall_err = 0;
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 2 * WORDS && out_valid; k++) begin
            d = out_data;
            a = out_addr;
            l = out_last;
            repeat ((mode == 2) ? 5 : (mode == 1) ? $urandom_range(0, 2) : 0) begin
                @(negedge clk);
                if (out_data !== d || out_addr !== a || out_last !== l || out_valid !== 1'b1)
                    stall_err++;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            got_data.push_back(d);
            got_addr.push_back(int'(a));
            got_last.push_back(l);
            if (l) break;
        end
    endtask

    function automatic int word_errors();
        int bad;
        bad = 0;
        if (got_data.size() != WORDS) return 99;
        for (int i = 0; i < WORDS; i++) begin
            if (got_addr[i] != i || got_last[i] != (i == WORDS - 1) || got_data[i] !== exp_blk[i*W +: W])
                bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pt_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || chk_code !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%0b vld=%0b busy=%0b chk=%0h required 0", pt_ready, out_valid, busy, chk_code);
        end
        checks++;
        if (out_data !== '0 || out_addr !== '0 || out_last !== 1'b0 || pt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_data got data=%0h addr=%0d last=%0b cnt=%0d required 0", out_data, out_addr, out_last, pt_count);
        end
    endtask

    task automatic test_basic();
        mask_mode = 0;
        start_frame();
        send_code(15'h0001, 1'b0, 0);
        send_code(15'h7FFF, 1'b1, 0);
        drain(0);
        checks++;
        if (got_data.size() != WORDS || got_data[0] !== 32'h0000_0002 || got_data[WORDS-1] !== 32'h8000_0000) begin
            failures++;
            $display("FAIL basic_words got n=%0d w0=%0h wlast=%0h required n=%0d 2 80000000", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 32'h0, (got_data.size() == WORDS) ? got_data[WORDS-1] : 32'h0, WORDS);
        end
        checks++;
        if (word_errors() != 0) begin
            failures++;
            $display("FAIL basic_addr_last got bad=%0d required 0", word_errors());
        end
        checks++;
        if (pt_count !== 16'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_count got cnt=%0d busy=%0b required 2 0", pt_count, busy);
        end
    endtask

    task automatic test_stall();
        mask_mode = 1;
        start_frame();
        for (int i = 0; i < 12; i++) send_code(CW'($urandom), i == 11, 1);
        drain(2);
        checks++;
        if (word_errors() != 0 || stall_err != 0) begin
            failures++;
            $display("FAIL stall_words got bad=%0d stall_err=%0d required 0 0", word_errors(), stall_err);
        end
    endtask

    task automatic test_back_to_back();
        int ones;
        mask_mode = 0;
        start_frame();
        for (int i = 0; i < 100; i++) send_code(CW'(($urandom_range(0, 255) * N) + i), i == 99, 0);
        drain(1);
        ones = 0;
        foreach (got_data[i]) ones += $countones(got_data[i]);
        checks++;
        if (ones != 100 || word_errors() != 0) begin
            failures++;
            $display("FAIL b2b_bits got ones=%0d bad=%0d required 100 0", ones, word_errors());
        end
        checks++;
        if (pt_count !== 16'd100) begin
            failures++;
            $display("FAIL b2b_count got %0d required 100", pt_count);
        end
`ifdef PRM_EDGE_POPCNT_EN
        checks++;
        if (blk_count !== BCW'(100)) begin
            failures++;
            $display("FAIL b2b_blk_count got %0d required 100", blk_count);
        end
`endif
    endtask

    task automatic test_random();
        int len;
        mask_mode = 1;
        for (int f = 0; f < 5; f++) begin
            start_frame();
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) send_code(CW'($urandom), i == len - 1, 2);
            drain(1);
            checks++;
            if (word_errors() != 0 || stall_err != 0 || pt_count !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL random_frame%0d got bad=%0d stall=%0d cnt=%0d required 0 0 %0d",
                         f, word_errors(), stall_err, pt_count, exp_cnt);
            end
`ifdef PRM_EDGE_POPCNT_EN
            checks++;
            if (blk_count !== BCW'($countones(exp_blk))) begin
                failures++;
                $display("FAIL random_blk_count%0d got %0d required %0d", f, blk_count, $countones(exp_blk));
            end
`endif
        end
    endtask

    task automatic test_reset_mid_drain();
        int t;
        mask_mode = 1;
        start_frame();
        for (int i = 0; i < 10; i++) send_code(CW'($urandom), i == 9, 0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_addr !== AW'(1) || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_drain_word1 got addr=%0d vld=%0b required 1 1", out_addr, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || pt_ready !== 1'b0 || chk_code !== '0 || pt_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_drain_outputs got vld=%0b data=%0h addr=%0d last=%0b busy=%0b rdy=%0b chk=%0h cnt=%0d required all 0",
                     out_valid, out_data, out_addr, out_last, busy, pt_ready, chk_code, pt_count);
        end
        start_frame();
        send_code(CW'($urandom), 1'b1, 0);
        drain(0);
        checks++;
        if (word_errors() != 0 || pt_count !== 16'd1) begin
            failures++;
            $display("FAIL rst_new_frame got bad=%0d cnt=%0d required 0 1", word_errors(), pt_count);
        end
    endtask

    task automatic test_frame_start_ignored();
        int t;
        mask_mode = 0;
        start_frame();
        send_code(15'h0005, 1'b0, 0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (pt_count !== 16'd1 || busy !== 1'b1 || pt_ready !== 1'b1) begin
            failures++;
            $display("FAIL fs_in_accum got cnt=%0d busy=%0b rdy=%0b required 1 1 1", pt_count, busy, pt_ready);
        end
        send_code(15'h0046, 1'b1, 0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        frame_start = 1'b1;
        pt_valid    = 1'b1;
        pt_last     = 1'b1;
        pt_code     = 15'h0011;
        @(negedge clk);
        frame_start = 1'b0;
        pt_valid    = 1'b0;
        pt_last     = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== '0 || pt_count !== 16'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fs_in_drain got vld=%0b addr=%0d cnt=%0d busy=%0b required 1 0 2 1", out_valid, out_addr, pt_count, busy);
        end
        drain(0);
        checks++;
        if (word_errors() != 0) begin
            failures++;
            $display("FAIL fs_drain_words got bad=%0d required 0", word_errors());
        end
        start_frame();
        send_code(15'h1234, 1'b1, 0);
        drain(1);
        checks++;
        if (word_errors() != 0 || pt_count !== 16'd1) begin
            failures++;
            $display("FAIL single_code_frame got bad=%0d cnt=%0d required 0 1", word_errors(), pt_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pt_valid    = 1'b0;
        pt_last     = 1'b0;
        pt_code     = '0;
        out_ready   = 1'b0;
        exp_blk     = '0;
        exp_cnt     = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        test_frame_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
